// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the IF and MEM pipeline stages.
// Each access runs IDLE grant -> WAIT for RAM_ACK -> one-cycle DONE with a VALID pulse.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic [DATA_W-1:0] IF_RDATA,
  output logic              IF_VALID,
  input  logic              MEM_REQ,
  input  logic              MEM_WE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_WDATA,
  output logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_VALID,
  output logic              RAM_REQ,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  input  logic              RAM_ACK,
  output logic              STALL_IF,
  output logic              STALL_MEM,
  output logic              ERR
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IF_WAIT, MEM_WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic              err_q, err_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              contested;
  logic              mem_wins;

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    err_d       = err_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    contested   = IF_REQ && MEM_REQ;
    mem_wins    = MEM_REQ && !(contested && (starve_q == STARVE_MAX));

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (mem_wins) begin
          ram_req_d   = 1'b1;
          ram_we_d    = MEM_WE;
          ram_addr_d  = MEM_ADDR;
          ram_wdata_d = MEM_WDATA;
          state_d     = MEM_WAIT;
          // A contested MEM win only happens below the limit, so this saturates.
          if (contested) starve_d = starve_q + 1'b1;
        end else if (IF_REQ) begin
          ram_req_d  = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = IF_ADDR;
          starve_d   = '0;
          state_d    = IF_WAIT;
        end
      end
      IF_WAIT, MEM_WAIT: begin
        if (RAM_ACK) begin
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          tmo_d     = '0;
          state_d   = DONE;
          if (state_q == IF_WAIT) begin
            if_rdata_d = RAM_RDATA;
            if_valid_d = 1'b1;
          end else begin
            if (!ram_we_q) mem_rdata_d = RAM_RDATA;
            mem_valid_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abort: requester keeps stalling and is re-arbitrated from IDLE.
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          err_d     = 1'b1;
          tmo_d     = '0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      err_q       <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      err_q       <= err_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
    end
  end

  assign RAM_REQ   = ram_req_q;
  assign RAM_WE    = ram_we_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = ram_wdata_q;
  assign IF_RDATA  = if_rdata_q;
  assign MEM_RDATA = mem_rdata_q;
  assign IF_VALID  = if_valid_q;
  assign MEM_VALID = mem_valid_q;
  assign ERR       = err_q;
  assign STALL_IF  = IF_REQ && !if_valid_q;
  assign STALL_MEM = MEM_REQ && !mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked
// every cycle against a transaction-level model of the sharing rules.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 15;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        ifReq = 1'b0, memReq = 1'b0, memWe = 1'b0, ramAck = 1'b0;
  logic [31:0] ifAddr = '0, memAddr = '0, memWdata = '0, ramRdata = '0;
  logic [31:0] IF_RDATA, MEM_RDATA, RAM_ADDR, RAM_WDATA;
  logic        IF_VALID, MEM_VALID, RAM_REQ, RAM_WE, STALL_IF, STALL_MEM, ERR;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .IF_REQ(ifReq), .IF_ADDR(ifAddr), .IF_RDATA(IF_RDATA), .IF_VALID(IF_VALID),
    .MEM_REQ(memReq), .MEM_WE(memWe), .MEM_ADDR(memAddr), .MEM_WDATA(memWdata),
    .MEM_RDATA(MEM_RDATA), .MEM_VALID(MEM_VALID),
    .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_RDATA(ramRdata), .RAM_ACK(ramAck),
    .STALL_IF(STALL_IF), .STALL_MEM(STALL_MEM), .ERR(ERR)
  );

  always #5 CLOCK = ~CLOCK;

  int compared = 0;
  int mismatched = 0;

  // Reference model: who holds the memory, how long it has waited, who is in DONE.
  int          busy, doneWho, elapsed, starve;
  logic        expErr, expWe;
  logic [31:0] expAddr, expWdata, expIfData, expMemData;

  // Memory responder knobs and grant log (1 = IF grant, 2 = MEM grant).
  bit          armed, noAck, spurious, useFixedRdata;
  int          delay, fixedDelay;
  logic [31:0] fixedRdata;
  logic        prevRamReq;
  int          grantQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    busy = 0; doneWho = 0; elapsed = 0; starve = 0;
    expErr = 1'b0; expWe = 1'b0;
    expAddr = '0; expWdata = '0; expIfData = '0; expMemData = '0;
    armed = 1'b0; prevRamReq = 1'b0;
  endtask

  // One clock edge of the sharing rules, using the inputs the DUT sampled.
  task automatic updateModel(input logic sIf, input logic sMem, input logic sWe,
                             input logic [31:0] sIfA, input logic [31:0] sMemA,
                             input logic [31:0] sWd, input logic sAck, input logic [31:0] sRd);
    int  oldDone = doneWho;
    bit  contested = sIf && sMem;
    doneWho = 0;
    if (busy != 0) begin
      if (sAck) begin
        doneWho = busy;
        if (busy == 1) expIfData = sRd;
        else if (!expWe) expMemData = sRd;
        expWe = 1'b0;
        busy = 0;
      end else begin
        elapsed++;
        if (elapsed == TIMEOUT) begin
          busy = 0; expWe = 1'b0; expErr = 1'b1;
        end
      end
    end else if (oldDone == 0) begin
      elapsed = 0;
      if (sMem && !(contested && starve == STARVE_LIMIT)) begin
        busy = 2; expAddr = sMemA; expWe = sWe; expWdata = sWd;
        if (contested) starve = (starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1;
      end else if (sIf) begin
        busy = 1; expAddr = sIfA; expWe = 1'b0; starve = 0;
      end
    end
  endtask

  task automatic checkAll(input logic sIf, input logic sMem);
    checkOutput("ram_req", RAM_REQ, busy != 0);
    checkOutput("ram_we", RAM_WE, expWe);
    checkOutput("ram_addr", RAM_ADDR, expAddr);
    checkOutput("ram_wdata", RAM_WDATA, expWdata);
    checkOutput("if_valid", IF_VALID, doneWho == 1);
    checkOutput("mem_valid", MEM_VALID, doneWho == 2);
    checkOutput("if_rdata", IF_RDATA, expIfData);
    checkOutput("mem_rdata", MEM_RDATA, expMemData);
    checkOutput("err", ERR, expErr);
    checkOutput("stall_if", STALL_IF, sIf && (doneWho != 1));
    checkOutput("stall_mem", STALL_MEM, sMem && (doneWho != 2));
  endtask

  // Memory side: ack after a chosen delay, a late ack after an abort, optional stray acks.
  task automatic driveMemory();
    ramAck = 1'b0;
    if (RAM_REQ) begin
      if (!armed) begin
        armed = 1'b1;
        if (noAck) delay = 1000;
        else if (fixedDelay >= 0) delay = fixedDelay;
        else delay = ($urandom_range(0, 24) == 0) ? 1000 : int'($urandom_range(0, 3));
      end
      if (delay == 0) begin
        ramAck = 1'b1;
        ramRdata = useFixedRdata ? fixedRdata : $urandom;
        armed = 1'b0;
      end else begin
        delay--;
      end
    end else if (armed) begin
      armed = 1'b0;
      ramAck = 1'b1;
      ramRdata = $urandom;
    end else if (spurious && $urandom_range(0, 9) == 0) begin
      ramAck = 1'b1;
      ramRdata = $urandom;
    end
  endtask

  task automatic runCycle();
    logic sIf = ifReq, sMem = memReq, sWe = memWe, sAck = ramAck;
    logic [31:0] sIfA = ifAddr, sMemA = memAddr, sWd = memWdata, sRd = ramRdata;
    @(posedge CLOCK);
    updateModel(sIf, sMem, sWe, sIfA, sMemA, sWd, sAck, sRd);
    @(negedge CLOCK);
    checkAll(sIf, sMem);
    if (RAM_REQ && !prevRamReq) grantQ.push_back((RAM_ADDR == ifAddr) ? 1 : 2);
    prevRamReq = RAM_REQ;
    driveMemory();
  endtask

  // Pipeline-like requesters: hold until VALID, then drop or issue a new request.
  task automatic applyStimulus();
    if (IF_VALID || !ifReq) begin
      ifReq = (IF_VALID ? $urandom_range(0, 1) : $urandom_range(0, 2)) == 0;
      ifAddr = $urandom & 32'hFFFF_FFFC;
    end
    if (MEM_VALID || !memReq) begin
      memReq = (MEM_VALID ? $urandom_range(0, 1) : $urandom_range(0, 2)) == 0;
      memWe = $urandom_range(0, 1) == 1;
      memAddr = $urandom & 32'hFFFF_FFFC;
      memWdata = $urandom;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int expSeq[6] = '{2, 2, 2, 2, 1, 2};
    logic [31:0] savedMem;
    fixedDelay = -1; noAck = 1'b0; spurious = 1'b0; useFixedRdata = 1'b0; fixedRdata = '0;
    resetModel();
    repeat (3) @(negedge CLOCK);
    checkOutput("rst_ram_req", RAM_REQ, 0);
    checkOutput("rst_ram_addr", RAM_ADDR, 0);
    checkOutput("rst_valids", {IF_VALID, MEM_VALID}, 0);
    checkOutput("rst_err", ERR, 0);
    RESET = 1'b1;

    // Single fetch, ack one cycle after RAM_REQ rises.
    $display("[TB] fetch with single-cycle ack latency");
    fixedDelay = 1; useFixedRdata = 1'b1; fixedRdata = 32'h8C22_0004;
    ifReq = 1'b1; ifAddr = 32'h0000_0040;
    #1 checkOutput("t1_stall_c0", STALL_IF, 1);
    runCycle();
    checkOutput("t1_req_c1", RAM_REQ, 1);
    checkOutput("t1_addr_c1", RAM_ADDR, 32'h40);
    runCycle();
    checkOutput("t1_req_c2", RAM_REQ, 1);
    checkOutput("t1_stall_c2", STALL_IF, 1);
    runCycle();
    checkOutput("t1_valid_c3", IF_VALID, 1);
    checkOutput("t1_rdata_c3", IF_RDATA, 32'h8C22_0004);
    ifReq = 1'b0; useFixedRdata = 1'b0;
    runCycle();

    // Contention: MEM first, IF granted at the next IDLE.
    $display("[TB] contested requests");
    fixedDelay = 0;
    ifReq = 1'b1; ifAddr = 32'h44; memReq = 1'b1; memWe = 1'b0; memAddr = 32'h100;
    n = 0;
    while (!IF_VALID && !MEM_VALID && n < 40) begin runCycle(); n++; end
    checkOutput("t2_first_mem", MEM_VALID, 1);
    checkOutput("t2_first_not_if", IF_VALID, 0);
    memReq = 1'b0;
    n = 0;
    while (!IF_VALID && n < 40) begin runCycle(); n++; end
    checkOutput("t2_if_latency", n, 3);
    ifReq = 1'b0;
    runCycle();

    // Starvation guard: four contested MEM wins, then IF once, then MEM again.
    $display("[TB] starvation guard");
    grantQ.delete();
    ifReq = 1'b1; ifAddr = 32'h2000; memReq = 1'b1; memWe = 1'b0; memAddr = 32'h100;
    n = 0;
    while (grantQ.size() < 6 && n < 200) begin
      runCycle(); n++;
      if (MEM_VALID) memAddr = memAddr + 32'd4;
      if (IF_VALID) ifAddr = ifAddr + 32'd4;
    end
    checkOutput("t3_grant_count", grantQ.size() >= 6, 1);
    for (int i = 0; i < 6 && i < grantQ.size(); i++)
      checkOutput($sformatf("t3_grant%0d", i), grantQ[i], expSeq[i]);
    n = 0;
    while (!MEM_VALID && n < 40) begin runCycle(); n++; end
    checkOutput("t3_last_valid", MEM_VALID, 1);
    ifReq = 1'b0; memReq = 1'b0;
    runCycle();

    // Write leaves load data untouched.
    $display("[TB] memory write");
    fixedDelay = 2; savedMem = expMemData;
    memReq = 1'b1; memWe = 1'b1; memAddr = 32'h200; memWdata = 32'hDEAD_BEEF;
    runCycle();
    checkOutput("t4_we", RAM_WE, 1);
    checkOutput("t4_wdata", RAM_WDATA, 32'hDEAD_BEEF);
    checkOutput("t4_addr", RAM_ADDR, 32'h200);
    n = 0;
    while (!MEM_VALID && n < 40) begin runCycle(); n++; end
    checkOutput("t4_valid", MEM_VALID, 1);
    checkOutput("t4_rdata_kept", MEM_RDATA, savedMem);
    memReq = 1'b0; memWe = 1'b0;
    runCycle();

    // Timeout, late ack ignored, request re-issued.
    $display("[TB] memory timeout");
    noAck = 1'b1;
    memReq = 1'b1; memAddr = 32'h300;
    runCycle();
    n = 0;
    while (RAM_REQ && n < 40) begin n++; runCycle(); end
    checkOutput("t5_wait_cycles", n, TIMEOUT);
    checkOutput("t5_err", ERR, 1);
    checkOutput("t5_req_dropped", RAM_REQ, 0);
    noAck = 1'b0; fixedDelay = 0;
    n = 0;
    while (!MEM_VALID && n < 40) begin runCycle(); n++; end
    checkOutput("t5_reissued_valid", MEM_VALID, 1);
    memReq = 1'b0;
    runCycle();

    // Reset in the middle of a MEM access, then a stale ack.
    $display("[TB] reset during access");
    noAck = 1'b1;
    memReq = 1'b1; memAddr = 32'h400;
    runCycle();
    runCycle();
    RESET = 1'b0; memReq = 1'b0; ramAck = 1'b0;
    #1;
    checkOutput("t6_req", RAM_REQ, 0);
    checkOutput("t6_addr", RAM_ADDR, 0);
    checkOutput("t6_valid", MEM_VALID, 0);
    checkOutput("t6_err", ERR, 0);
    checkOutput("t6_mem_rdata", MEM_RDATA, 0);
    checkOutput("t6_if_rdata", IF_RDATA, 0);
    resetModel();
    @(negedge CLOCK);
    RESET = 1'b1; noAck = 1'b0; fixedDelay = -1;
    ramAck = 1'b1; ramRdata = 32'h1234_5678;
    runCycle();
    checkOutput("t6_late_ack_valid", MEM_VALID, 0);
    runCycle();
    checkOutput("t6_idle_req", RAM_REQ, 0);

    // Random traffic with random latencies, occasional timeouts and stray acks.
    $display("[TB] random traffic");
    spurious = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      applyStimulus();
      runCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
